// File: rtl/shadow_snapshot_fifo.sv
// Ring buffer of timestamped snapshots of a wide vector; the oldest entry is
// dumped over CHAINS parallel serial chains with valid and done strobes.
module shadow_snapshot_fifo #(
  parameter int DIN_BITS = 1181,
  parameter int TS_BITS  = 16,
  parameter int DEPTH    = 4,
  parameter int CHAINS   = 6,
  parameter bit WRAP     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_en,
  input  logic [DIN_BITS-1:0]          din,
  input  logic                         dump_en,
  input  logic                         clr_ovf,
  output logic [CHAINS-1:0]            chains_out,
  output logic [CHAINS-1:0]            chains_out_vld,
  output logic [CHAINS-1:0]            chains_out_done,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         dumping
);
  localparam int W     = DIN_BITS + TS_BITS;
  localparam int L     = (W + CHAINS - 1) / CHAINS;
  localparam int PW    = CHAINS * L;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int K_W   = (L > 1) ? $clog2(L) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t             state;
  logic [K_W-1:0]     k;
  logic [TS_BITS-1:0] ts;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [W-1:0]       mem [DEPTH];
  logic [L-1:0]       sr_p1 [CHAINS];

  logic               load, wr_en, rd_adv, ovf_evt;
  logic [CNT_W-1:0]   count_nxt;
  logic [PW-1:0]      pay_p0;
  logic [L-1:0]       chain_p0 [CHAINS];
  logic [CHAINS-1:0]  first_bits, next_bits;

  // Buffer bookkeeping: a pop in the same cycle frees the slot a full-buffer capture needs.
  always_comb begin
    load      = (state == IDLE) && dump_en && (count != '0);
    ovf_evt   = capture_en && full && !load;
    wr_en     = capture_en && (load || !full || WRAP);
    rd_adv    = load || (ovf_evt && WRAP);
    count_nxt = count;
    if (wr_en && !rd_adv)
      count_nxt = count + 1'b1;
    else if (!wr_en && rd_adv)
      count_nxt = count - 1'b1;
  end

  always_comb begin
    pay_p0     = PW'(mem[rd_ptr]);
    first_bits = '0;
    next_bits  = '0;
    for (int c = 0; c < CHAINS; c++) begin
      chain_p0[c]   = pay_p0[c*L +: L];
      first_bits[c] = pay_p0[c*L];
      next_bits[c]  = sr_p1[c][0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts              <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      empty           <= 1'b1;
      full            <= 1'b0;
      overflow        <= 1'b0;
      state           <= IDLE;
      k               <= '0;
      chains_out      <= '0;
      chains_out_vld  <= '0;
      chains_out_done <= '0;
      dumping         <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (wr_en)  wr_ptr <= ptr_inc(wr_ptr);
      if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
      if (ovf_evt)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            state           <= SHIFT;
            k               <= '0;
            chains_out      <= first_bits;
            chains_out_vld  <= '1;
            chains_out_done <= {CHAINS{L == 1}};
            dumping         <= 1'b1;
          end else begin
            chains_out      <= '0;
            chains_out_vld  <= '0;
            chains_out_done <= '0;
          end
        end
        SHIFT: begin
          if (int'(k) == L - 1) begin
            state           <= IDLE;
            chains_out      <= '0;
            chains_out_vld  <= '0;
            chains_out_done <= '0;
            dumping         <= 1'b0;
          end else begin
            k               <= k + 1'b1;
            chains_out      <= next_bits;
            chains_out_done <= {CHAINS{int'(k) == L - 2}};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {ts, din};
    for (int c = 0; c < CHAINS; c++) begin
      if (load)
        sr_p1[c] <= chain_p0[c] >> 1;
      else if (state == SHIFT)
        sr_p1[c] <= sr_p1[c] >> 1;
    end
  end

endmodule

// File: tb/tb_shadow_snapshot_fifo.sv
// Randomized bench for shadow_snapshot_fifo: a drop-policy and an overwrite-policy
// instance share stimulus and are compared every cycle against queue-based models.
module tb_shadow_snapshot_fifo;
  localparam int DIN_BITS = 1181;
  localparam int TS_BITS  = 16;
  localparam int DEPTH    = 4;
  localparam int CHAINS   = 6;
  localparam int W        = DIN_BITS + TS_BITS;
  localparam int L        = (W + CHAINS - 1) / CHAINS;
  localparam int PW       = CHAINS * L;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                capture_en = 1'b0;
  logic                dump_en = 1'b0;
  logic                clr_ovf = 1'b0;
  logic [DIN_BITS-1:0] din = '0;

  logic [CHAINS-1:0]   co [2];
  logic [CHAINS-1:0]   cv [2];
  logic [CHAINS-1:0]   cd [2];
  logic [CNT_W-1:0]    cnt [2];
  logic                emp [2];
  logic                ful [2];
  logic                ovf [2];
  logic                dmp [2];

  always #5 clk = ~clk;

  shadow_snapshot_fifo #(.DIN_BITS(DIN_BITS), .TS_BITS(TS_BITS), .DEPTH(DEPTH),
                         .CHAINS(CHAINS), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .capture_en(capture_en), .din(din), .dump_en(dump_en),
    .clr_ovf(clr_ovf), .chains_out(co[0]), .chains_out_vld(cv[0]),
    .chains_out_done(cd[0]), .count(cnt[0]), .empty(emp[0]), .full(ful[0]),
    .overflow(ovf[0]), .dumping(dmp[0]));

  shadow_snapshot_fifo #(.DIN_BITS(DIN_BITS), .TS_BITS(TS_BITS), .DEPTH(DEPTH),
                         .CHAINS(CHAINS), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .capture_en(capture_en), .din(din), .dump_en(dump_en),
    .clr_ovf(clr_ovf), .chains_out(co[1]), .chains_out_vld(cv[1]),
    .chains_out_done(cd[1]), .count(cnt[1]), .empty(emp[1]), .full(ful[1]),
    .overflow(ovf[1]), .dumping(dmp[1]));

  logic [W-1:0]       q0 [$];
  logic [W-1:0]       q1 [$];
  logic [TS_BITS-1:0] m_ts;
  bit                 m_busy [2];
  int                 m_step [2];
  logic [W-1:0]       m_cur [2];
  bit                 m_ovf [2];
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_push(input int i, input logic [W-1:0] v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic q_pop(input int i, output logic [W-1:0] v);
    if (i == 0) v = q0.pop_front(); else v = q1.pop_front();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ts = '0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_step[i] = 0;
      m_cur[i]  = '0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs presented to the DUT.
  task automatic model_edge();
    logic [W-1:0] p, tmp;
    bit full_b, load, evt;
    p = {m_ts, din};
    for (int i = 0; i < 2; i++) begin
      full_b = (qsize(i) == DEPTH);
      load   = 1'b0;
      evt    = 1'b0;
      if (m_busy[i]) begin
        if (m_step[i] == L - 1) m_busy[i] = 1'b0;
        else m_step[i]++;
      end else if (dump_en && qsize(i) > 0) begin
        q_pop(i, tmp);
        m_cur[i]  = tmp;
        m_busy[i] = 1'b1;
        m_step[i] = 0;
        load      = 1'b1;
      end
      if (capture_en) begin
        if (full_b && !load) begin
          evt = 1'b1;
          if (i == 1) begin
            q_pop(i, tmp);
            q_push(i, p);
          end
        end else begin
          q_push(i, p);
        end
      end
      if (clr_ovf) m_ovf[i] = 1'b0;
      if (evt) m_ovf[i] = 1'b1;
    end
    m_ts++;
  endtask

  task automatic check_all();
    logic [CHAINS-1:0] ec;
    int idx;
    for (int i = 0; i < 2; i++) begin
      ec = '0;
      for (int c = 0; c < CHAINS; c++) begin
        idx = c * L + m_step[i];
        if (m_busy[i] && idx < W) ec[c] = m_cur[i][idx];
      end
      chk($sformatf("dut%0d chains_out cyc%0d", i, cyc), 64'(co[i]), 64'(ec));
      chk($sformatf("dut%0d vld cyc%0d", i, cyc), 64'(cv[i]),
          m_busy[i] ? 64'((1 << CHAINS) - 1) : 64'd0);
      chk($sformatf("dut%0d done cyc%0d", i, cyc), 64'(cd[i]),
          (m_busy[i] && m_step[i] == L - 1) ? 64'((1 << CHAINS) - 1) : 64'd0);
      chk($sformatf("dut%0d count cyc%0d", i, cyc), 64'(cnt[i]), 64'(qsize(i)));
      chk($sformatf("dut%0d empty cyc%0d", i, cyc), 64'(emp[i]), 64'(qsize(i) == 0));
      chk($sformatf("dut%0d full cyc%0d", i, cyc), 64'(ful[i]), 64'(qsize(i) == DEPTH));
      chk($sformatf("dut%0d overflow cyc%0d", i, cyc), 64'(ovf[i]), 64'(m_ovf[i]));
      chk($sformatf("dut%0d dumping cyc%0d", i, cyc), 64'(dmp[i]), 64'(m_busy[i]));
    end
  endtask

  task automatic tick(input bit cap, input logic [DIN_BITS-1:0] d, input bit dmp_i, input bit clr);
    capture_en = cap;
    din        = d;
    dump_en    = dmp_i;
    clr_ovf    = clr;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    cyc++;
    check_all();
  endtask

  function automatic logic [DIN_BITS-1:0] rand_din();
    logic [DIN_BITS-1:0] v;
    v = '0;
    for (int w = 0; w < (DIN_BITS + 31) / 32; w++)
      v = (v << 32) | DIN_BITS'($urandom());
    return v;
  endfunction

  initial begin
    logic [DIN_BITS-1:0] pat;
    logic [PW-1:0]       rx;
    int                  s, guard;

    model_reset();
    #1 rst = 1'b0;
    #2 check_all();
    tick(0, '0, 0, 0);
    tick(0, '0, 0, 0);
    rst = 1'b1;

    // Single capture at ts=5, then a full dump with payload reassembly.
    for (int i = 0; i < 5; i++) tick(0, '0, 0, 0);
    pat = {29'h1EADBEEF, {36{32'hDEADBEEF}}};
    tick(1, pat, 0, 0);
    rx = '0;
    s  = 0;
    for (int n = 0; n < L + 3; n++) begin
      tick(0, '0, 1, 0);
      if (cv[0][0] === 1'b1) begin
        for (int c = 0; c < CHAINS; c++) rx[c*L + s] = co[0][c];
        s++;
      end
    end
    chk("burst length", 64'(s), 64'(L));
    chk("reassembled ts", 64'(rx[W-1:DIN_BITS]), 64'h5);
    chk("reassembled din", 64'(rx[DIN_BITS-1:0] == pat), 64'd1);
    chk("pad bits", 64'(rx[PW-1:W]), 64'd0);

    // Five captures into four slots: drop versus overwrite.
    for (int i = 0; i < 5; i++) tick(1, rand_din(), 0, 0);
    chk("dut0 full after 5", 64'(ful[0]), 64'd1);
    chk("dut1 overflow after 5", 64'(ovf[1]), 64'd1);
    for (int n = 0; n < 4 * (L + 1) + 3; n++) tick(0, '0, 1, 0);
    tick(0, '0, 0, 1);

    // Full buffer with capture and dump load in the same cycle.
    for (int i = 0; i < 4; i++) tick(1, rand_din(), 0, 0);
    tick(1, rand_din(), 1, 0);
    chk("dut0 no ovf on pop+cap", 64'(ovf[0]), 64'd0);
    for (int n = 0; n < 4 * (L + 1) + 5; n++) tick(0, '0, 1, 0);

    // Random traffic with captures landing mid-burst.
    for (int n = 0; n < 1500; n++)
      tick($urandom_range(0, 7) == 0, rand_din(), $urandom_range(0, 9) != 0,
           $urandom_range(0, 31) == 0);
    for (int n = 0; n < 6 * (L + 1); n++) tick(0, '0, 1, 0);

    // Reset in the middle of a shift.
    tick(1, rand_din(), 0, 0);
    guard = 0;
    while (!(m_busy[0] && m_step[0] == 100) && guard < 400) begin
      tick(0, '0, 1, 0);
      guard++;
    end
    chk("reach shift step 100", 64'(guard < 400), 64'd1);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    tick(0, '0, 1, 0);
    tick(0, '0, 1, 0);
    rst = 1'b1;
    for (int n = 0; n < 20; n++) tick(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shadow_snapshot_fifo.md
# shadow_snapshot_fifo

Parametrised successor to the single-shot shadow capture block. It stores up to DEPTH timestamped snapshots of a wide internal vector in a ring buffer and dumps the oldest one over CHAINS parallel serial scan chains. Each bit arrives with a valid strobe and a final done pulse. It sits beside the logic under observation, in the same clock domain, and feeds the scan-out collector.

## Interface
- DIN_BITS, 1181, width of the observed vector `din`
- TS_BITS, 16, width of the free-running timestamp stored with each snapshot (≥1)
- DEPTH, 4, number of snapshot slots (≥1)
- CHAINS, 6, number of serial output chains (≥1)
- WRAP, 0, full-buffer policy: 0 = drop new capture, 1 = overwrite oldest entry
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state and outputs immediately
- capture_en  in  1  on a rising edge, write {timestamp, din} into the buffer
- din  in  DIN_BITS  observed vector
- dump_en  in  1  level; requests a dump of the oldest entry
- clr_ovf  in  1  clears sticky `overflow`
- chains_out  out  CHAINS  serial data, one bit per chain
- chains_out_vld  out  CHAINS  per-chain valid (all bits identical)
- chains_out_done  out  CHAINS  per-chain last-bit strobe (all bits identical)
- count  out  $clog2(DEPTH+1)  occupied slots
- empty / full  out  1 each  count==0 / count==DEPTH
- overflow  out  1  sticky; set when a capture is dropped or an entry is overwritten
- dumping  out  1  high while in SHIFT

## Operation
- Payload P = {ts, din}, W = DIN_BITS+TS_BITS. Chain length L = ceil(W/CHAINS). Chain c, shift step k (0..L-1) carries P[c*L+k]; indices ≥ W read as 0.
- Timestamp counter: resets to 0, increments every cycle, wraps modulo 2^TS_BITS. The value sampled at the capture edge is the one stored.
- Capture when not full: write to slot wr_ptr; wr_ptr++ (mod DEPTH); count++.
- Capture when full and WRAP=0: capture is dropped and overflow is set.
- Capture when full and WRAP=1: capture overwrites the oldest entry; rd_ptr++ and wr_ptr++; count is unchanged; overflow is set.
- FSM IDLE: if dump_en && count>0, copy slot rd_ptr into a CHAINS×L shift register, then rd_ptr++, count-- (the slot is freed at load), and go to SHIFT with k=0.
- FSM SHIFT: chains_out[c] = P[c*L+k], vld = all ones. At k=L-1, done = all ones and next state is IDLE. Otherwise k++.
- Capture and dump-load in the same cycle: both pointers advance and count is unchanged. When full, this is not an overflow, since pop wins the slot.
- Capture during SHIFT is legal and does not disturb the shift register.
- dump_en is sampled only in IDLE; dropping it mid-SHIFT does not abort the dump.
- clr_ovf clears overflow. If clr_ovf and a new overflow event occur in the same cycle, the set wins.

## Timing
- Reset values: chains_out=0, vld=0, done=0, count=0, empty=1, full=0, overflow=0, dumping=0, pointers=0, ts=0, FSM=IDLE.
- All outputs are registered.
- count, full, empty and overflow reflect a capture from the cycle after the capture edge.
- Dump latency: if the load condition is true in cycle t, the first bit (k=0) is on chains_out in cycle t+1 and the last bit is in cycle t+L together with done.
- When dump_en is held, the next load occurs in cycle t+L+1, so the first bit of the next snapshot appears at t+L+2: exactly one gap cycle with vld=0.
- A capture in cycle t with count==0 makes that entry dumpable from cycle t+1.
- Asserting rst mid-SHIFT clears outputs immediately and discards all buffered entries.

## Test plan
- Reset, then din={29'h1EADBEEF,{36{32'hDEADBEEF}}} and capture_en for 1 cycle at ts=5, then dump_en=1 -> L=200 vld cycles per chain. Reassembling P gives din with ts=16'h0005 at P[1196:1181]; chain 5 steps 197..199 read 0; done appears only on step 199; count goes 1→0.
- Five captures with WRAP=0, DEPTH=4 -> count=4, full=1, overflow=1. The dumped order is captures 1..4 (by timestamp); the 5th capture is absent.
- Same stimulus with WRAP=1 -> dumped order is captures 2..5; overflow=1; pulsing clr_ovf clears it.
- Buffer full, capture_en and the dump load in the same cycle -> count stays 4, overflow stays 0, and the newest entry is dumped last.
- Three entries with dump_en held high -> three 200-bit bursts, each separated by exactly one vld=0 cycle. Captures inserted mid-burst are dumped in order afterwards.
- rst asserted at shift step 100 -> outputs are 0 immediately. After release, count=0 and a dump_en with no capture produces no vld.
